// File: rtl/seq_div_pkg.sv
// Shared FSM encoding for the sequential divider (and the multiplier bench decode).
// Build option: SEQ_DIV_ZERO_DETECT_EN (see seq_div.sv).
package seq_div_pkg;

   localparam int         ST_W    = 2;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_div_step.sv
// One restoring shift-compare-subtract iteration of the divider (combinational).
module div_step #(
   parameter int W = 4
) (
   input  logic [W:0]     rem,
   input  logic [2*W-1:0] quo,
   input  logic [W-1:0]   dvs,
   output logic [W:0]     rem_next,
   output logic [2*W-1:0] quo_next
);

   logic [W+1:0] rem_sh;
   logic [W+1:0] diff;
   logic         ge;

   // NOTE: pure combinational block -- blocking '=' and every output assigned on every path, so no latch.
   always_comb begin
      rem_sh   = {rem, quo[2*W-1]};
      diff     = rem_sh - {2'b00, dvs};
      ge       = rem_sh >= {2'b00, dvs};
      rem_next = ge ? diff[W:0] : rem_sh[W:0];
      quo_next = {quo[2*W-2:0], ge};
   end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Build option: SEQ_DIV_ZERO_DETECT_EN short-circuits b==0 straight to DONE and drives div0.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld,
   input  logic [2*W-1:0] a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] rq,
   output logic [W-1:0]   rr,
   output logic           busy,
   output logic           done,
   output logic           div0
);

   localparam int            CW   = $clog2(2*W);
   localparam logic [CW-1:0] LAST = CW'(2*W-1);

   logic [ST_W-1:0] state;
   logic [W:0]      rem;
   logic [2*W-1:0]  quo;
   logic [W-1:0]    dvs;
   logic [CW-1:0]   cnt;
   logic [W:0]      rem_next;
   logic [2*W-1:0]  quo_next;

   div_step #(.W(W)) u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

`ifdef SEQ_DIV_ZERO_DETECT_EN
   logic div0_q;
   assign div0 = div0_q;
`else
   assign div0 = 1'b0;
`endif

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   // NOTE: state registers use non-blocking '<=' only; the synchronous reset clears every register here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         rq    <= '0;
         rr    <= '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
         div0_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (ld) begin
                  quo   <= a;
                  rem   <= '0;
                  dvs   <= b;
                  cnt   <= '0;
                  state <= ST_RUN;
`ifdef SEQ_DIV_ZERO_DETECT_EN
                  div0_q <= 1'b0;
                  if (b == '0) begin
                     state  <= ST_DONE;
                     rq     <= '1;
                     rr     <= a[W-1:0];
                     div0_q <= 1'b1;
                  end
`endif
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + 1'b1;
               // Results publish only on the final iteration; they hold otherwise.
               if (cnt == LAST) begin
                  rq    <= quo_next;
                  rr    <= rem_next[W-1:0];
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (W=4); honours SEQ_DIV_ZERO_DETECT_EN.
module tb_seq_div;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           ld;
   logic [2*W-1:0] a;
   logic [W-1:0]   b;
   logic [2*W-1:0] rq;
   logic [W-1:0]   rr;
   logic           busy;
   logic           done;
   logic           div0;

   int errors = 0;
   int checks = 0;

   seq_div #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .ld   (ld),
      .a    (a),
      .b    (b),
      .rq   (rq),
      .rr   (rr),
      .busy (busy),
      .done (done),
      .div0 (div0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive ld for exactly one edge; returns #1 after that load edge.
   task automatic start(input logic [2*W-1:0] av, input logic [W-1:0] bv);
      ld = 1'b1;
      a  = av;
      b  = bv;
      tick();
      ld = 1'b0;
   endtask

   // Counts edges from now until done is seen; n=-1 if the bound expires.
   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      if (!done) n = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ld  = 1'b0;
      a   = '0;
      b   = '0;
      tick();
      rst = 1'b0;
      chk("reset_rq", int'(rq), 0);
      chk("reset_rr", int'(rr), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_div0", int'(div0), 0);
   endtask

   task automatic test_basic();
      int n;
      start(8'd99, 4'd11);
      chk("basic_busy", int'(busy), 1);
      wait_done(0, n);
      chk("basic_latency", n, 8);
      chk("basic_rq", int'(rq), 9);
      chk("basic_rr", int'(rr), 0);
      chk("basic_div0", int'(div0), 0);
      chk("basic_busy_at_done", int'(busy), 0);
      tick();
      chk("basic_done_one_cycle", int'(done), 0);
   endtask

   task automatic test_back_to_back();
      int n;
      start(8'd200, 4'd7);
      wait_done(0, n);
      chk("b2b_first_latency", n, 8);
      chk("b2b_first_rq", int'(rq), 28);
      chk("b2b_first_rr", int'(rr), 4);
      // ld held on the done cycle itself
      start(8'd255, 4'd1);
      chk("b2b_restart_busy", int'(busy), 1);
      chk("b2b_restart_done", int'(done), 0);
      chk("b2b_rq_held", int'(rq), 28);
      wait_done(0, n);
      chk("b2b_second_latency", n, 8);
      chk("b2b_second_rq", int'(rq), 255);
      chk("b2b_second_rr", int'(rr), 0);
   endtask

   task automatic test_div_zero();
      int n;
      tick();
      start(8'hA5, 4'd0);
`ifdef SEQ_DIV_ZERO_DETECT_EN
      chk("div0_busy", int'(busy), 0);
      wait_done(0, n);
      chk("div0_latency", n, 0);
      chk("div0_flag", int'(div0), 1);
`else
      wait_done(0, n);
      chk("div0_latency", n, 8);
      chk("div0_flag", int'(div0), 0);
`endif
      chk("div0_rq", int'(rq), 8'hFF);
      chk("div0_rr", int'(rr), 4'h5);
   endtask

   task automatic test_ld_during_run();
      int n;
      tick();
      start(8'd99, 4'd11);
      tick();
      tick();
      ld = 1'b1;
      a  = 8'd50;
      b  = 4'd5;
      tick();
      ld = 1'b0;
      a  = 8'd0;
      b  = 4'd3;
      chk("ignore_busy", int'(busy), 1);
      wait_done(3, n);
      chk("ignore_latency", n, 8);
      chk("ignore_rq", int'(rq), 9);
      chk("ignore_rr", int'(rr), 0);
      chk("ignore_div0", int'(div0), 0);
   endtask

   task automatic test_reset_mid_run();
      int n;
      int seen;
      tick();
      start(8'd77, 4'd3);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_rq", int'(rq), 0);
      chk("midrst_rr", int'(rr), 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) seen++;
         tick();
      end
      chk("midrst_no_done", seen, 0);
      start(8'd99, 4'd11);
      wait_done(0, n);
      chk("midrst_fresh_latency", n, 8);
      chk("midrst_fresh_rq", int'(rq), 9);
      chk("midrst_fresh_rr", int'(rr), 0);
   endtask

   task automatic test_sweep();
      int n;
      int bad;
      bad = 0;
      for (int x = 0; x < 256; x++) begin
         for (int y = 1; y < 16; y++) begin
            start(8'(x), 4'(y));
            wait_done(0, n);
            if (n != 8 || int'(rq) * y + int'(rr) != x || int'(rr) >= y || int'(rq) != x / y) begin
               if (bad < 5)
                  $display("FAIL sweep %0d/%0d: got rq=%0d rr=%0d lat=%0d expected rq=%0d rr=%0d lat=8",
                           x, y, rq, rr, n, x / y, x % y);
               bad++;
            end
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ld_during_run();
      test_reset_mid_run();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
